// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: data width, default access
// timeout and the controller state encoding.
package mem_stage_pkg;

   localparam int XLEN            = 64;
   localparam int TIMEOUT_DEFAULT = 255;
   localparam int TCNT_W          = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2,
      ST_DONE   = 2'd3
   } mem_state_e;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Access watchdog: counts cycles while enabled; expired is raised during the
// cycle that would bring the count up to the limit.
module dmem_timeout_ctr
   import mem_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              enable,
   input  logic [TCNT_W-1:0] limit,
   output logic              expired
);

   logic [TCNT_W-1:0] cnt_q;
   logic [TCNT_W-1:0] cnt_d;

   // next count: clear wins, then saturating increment while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != {TCNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // widened compare so the +1 cannot wrap
   assign expired = enable && (({1'b0, cnt_q} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: takes the execute bundle, performs the ld/sd on
// the valid/ready data-memory channel and returns a one-cycle writeback
// bundle. All outputs are registered from the next-state values.
// Optional build macro: MEM_ALIGN_CHECK_EN (fault misaligned ld/sd, no request).
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for start; watchdog held clear
// ST_REQ    | dmem_req high, addr/we/wdata stable until dmem_ready
// ST_WAIT_R | load accepted, waiting for dmem_rvalid
// ST_DONE   | done pulse with writeback bundle, back to idle
module mem_access_unit
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] ALUResult,
   input  logic [XLEN-1:0] WriteData,
   input  logic [4:0]      RdIn,
   input  logic            MemRead,
   input  logic            MemWrite,
   input  logic            MemtoReg,
   input  logic            RegWrite,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] WBData,
   output logic [4:0]      WBRd,
   output logic            WBRegWrite,
   output logic            fault,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ready,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata
);

   localparam logic [TCNT_W-1:0] TIMEOUT_LIM = TCNT_W'(TIMEOUT);

   mem_state_e state_q, state_d;

   logic [XLEN-1:0] alu_q, alu_d, rdata_q, rdata_d;
   logic [4:0]      rd_q, rd_d;
   logic            mtr_q, mtr_d, rw_q, rw_d;

   logic            busy_q, busy_d, done_q, done_d, fault_q, fault_d;
   logic [XLEN-1:0] wbdata_q, wbdata_d;
   logic [4:0]      wbrd_q, wbrd_d;
   logic            wbrw_q, wbrw_d;
   logic            req_q, req_d, we_q, we_d;
   logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;

   logic            abort;
   logic            misaligned;
   logic            tmo_clear, tmo_enable, tmo_expired;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = (MemRead ^ MemWrite) && (ALUResult[2:0] != 3'd0);
`else
   assign misaligned = 1'b0;
`endif

   assign tmo_clear  = (state_q == ST_IDLE);
   assign tmo_enable = (state_q == ST_REQ) || (state_q == ST_WAIT_R);

   dmem_timeout_ctr u_tmo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .limit   (TIMEOUT_LIM),
      .expired (tmo_expired)
   );

   // next state, bundle latch and registered-output values
   always_comb begin
      state_d = state_q;
      alu_d   = alu_q;
      rdata_d = rdata_q;
      rd_d    = rd_q;
      mtr_d   = mtr_q;
      rw_d    = rw_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      abort   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               alu_d   = ALUResult;
               rd_d    = RdIn;
               mtr_d   = MemtoReg;
               rw_d    = RegWrite;
               rdata_d = '0;
               if ((MemRead && MemWrite) || misaligned) begin
                  abort   = 1'b1;
                  state_d = ST_DONE;
               end else if (MemRead || MemWrite) begin
                  addr_d  = ALUResult;
                  wdata_d = WriteData;
                  we_d    = MemWrite;
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_REQ: begin
            // completion takes priority over an expiring watchdog
            if (dmem_ready) begin
               state_d = we_q ? ST_DONE : ST_WAIT_R;
            end else if (tmo_expired) begin
               abort   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_WAIT_R: begin
            if (dmem_rvalid) begin
               rdata_d = dmem_rdata;
               state_d = ST_DONE;
            end else if (tmo_expired) begin
               abort   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // request fields are only driven while a request is pending
      if (state_d != ST_REQ) begin
         we_d    = 1'b0;
         addr_d  = '0;
         wdata_d = '0;
      end

      busy_d   = (state_d != ST_IDLE);
      req_d    = (state_d == ST_REQ);
      done_d   = (state_d == ST_DONE);
      fault_d  = done_d && abort;
      wbdata_d = done_d ? (mtr_d ? rdata_d : alu_d) : '0;
      wbrd_d   = done_d ? rd_d : 5'd0;
      wbrw_d   = done_d && rw_d && !abort && (rd_d != 5'd0);
   end

   // state, latched bundle and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         alu_q    <= '0;
         rdata_q  <= '0;
         rd_q     <= '0;
         mtr_q    <= 1'b0;
         rw_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         wbdata_q <= '0;
         wbrd_q   <= '0;
         wbrw_q   <= 1'b0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         alu_q    <= alu_d;
         rdata_q  <= rdata_d;
         rd_q     <= rd_d;
         mtr_q    <= mtr_d;
         rw_q     <= rw_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
         wbdata_q <= wbdata_d;
         wbrd_q   <= wbrd_d;
         wbrw_q   <= wbrw_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign WBData     = wbdata_q;
   assign WBRd       = wbrd_q;
   assign WBRegWrite = wbrw_q;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with TIMEOUT = 4: directed cases followed by
// randomized ld/sd/ALU/illegal instructions against a cycle-count model.
// Honours MEM_ALIGN_CHECK_EN when defined.
module tb_mem_access_unit;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] ALUResult = '0, WriteData = '0;
   logic [4:0]  RdIn = '0;
   logic        MemRead = 1'b0, MemWrite = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
   logic        busy, done, WBRegWrite, fault, dmem_req, dmem_we;
   logic [63:0] WBData, dmem_addr, dmem_wdata;
   logic [4:0]  WBRd;
   logic        dmem_ready = 1'b0, dmem_rvalid = 1'b0;
   logic [63:0] dmem_rdata = '0;

   int n_checks = 0;
   int n_pass   = 0;

   mem_access_unit #(.TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .ALUResult(ALUResult), .WriteData(WriteData), .RdIn(RdIn),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .busy(busy), .done(done), .WBData(WBData), .WBRd(WBRd),
      .WBRegWrite(WBRegWrite), .fault(fault),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // r: REQ cycles before dmem_ready (ready in REQ cycle r+1)
   // v: WAIT_R cycles before dmem_rvalid (rvalid in WAIT_R cycle v+1)
   task automatic run_op(input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic mtr, input logic rw,
                         input int r, input int v, input logic [63:0] rdat, input logic inject);
      int  exp_lat, exp_reqs, k, edges, req_cnt, w_cnt;
      logic exp_fault, got_ready, finished, bad;

      // reference: every cycle in REQ/WAIT_R is numbered from 1; an access
      // aborts at the first cycle numbered >= T in which it does not complete
      bad = mr && mw;
`ifdef MEM_ALIGN_CHECK_EN
      if ((mr ^ mw) && (alu[2:0] != 3'd0)) bad = 1'b1;
`endif
      if (bad) begin
         exp_lat = 1; exp_reqs = 0; exp_fault = 1'b1;
      end else if (!mr && !mw) begin
         exp_lat = 1; exp_reqs = 0; exp_fault = 1'b0;
      end else if (r + 1 > T) begin
         exp_lat = T + 1; exp_reqs = T; exp_fault = 1'b1;
      end else if (mw) begin
         exp_lat = r + 2; exp_reqs = r + 1; exp_fault = 1'b0;
      end else begin
         exp_reqs = r + 1;
         k = r + 2 + v;
         if (v == 0 || k <= T) begin
            exp_lat = k + 1; exp_fault = 1'b0;
         end else begin
            exp_lat = ((T > r + 2) ? T : r + 2) + 1; exp_fault = 1'b1;
         end
      end

      @(negedge clk);
      ALUResult = alu; WriteData = wd; RdIn = rd;
      MemRead = mr; MemWrite = mw; MemtoReg = mtr; RegWrite = rw;
      start = 1'b1;
      @(posedge clk);
      edges = 1; req_cnt = 0; w_cnt = 0; got_ready = 1'b0; finished = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         start = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
         if (inject && cyc == 0) begin
            // must be dropped: the unit is busy or finishing
            ALUResult = 64'h5555; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b1; RdIn = 5'd3;
            start = 1'b1;
         end
         if (done) begin
            chk("latency", 64'(edges), 64'(exp_lat));
            chk("fault", 64'(fault), 64'(exp_fault));
            chk("busy_at_done", 64'(busy), 64'd1);
            chk("req_cycles", 64'(req_cnt), 64'(exp_reqs));
            chk("wb_rd", 64'(WBRd), 64'(rd));
            chk("wb_regwrite", 64'(WBRegWrite), 64'(rw && !exp_fault && rd != 5'd0));
            if (!exp_fault) chk("wb_data", WBData, mtr ? rdat : alu);
            finished = 1'b1;
            break;
         end
         if (dmem_req) begin
            req_cnt++;
            chk("req_addr", dmem_addr, alu);
            chk("req_we", 64'(dmem_we), 64'(mw));
            if (mw) chk("req_wdata", dmem_wdata, wd);
            if (req_cnt == r + 1) begin
               dmem_ready = 1'b1; got_ready = 1'b1;
            end
         end else if (busy && got_ready) begin
            w_cnt++;
            if (w_cnt == v + 1) begin
               dmem_rvalid = 1'b1; dmem_rdata = rdat;
            end
         end
         @(posedge clk);
         edges++;
      end
      if (!finished) chk("done_timeout", 64'd0, 64'd1);
      @(negedge clk);
      start = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_after", 64'(busy), 64'd0);
      chk("req_low_after", 64'(dmem_req), 64'd0);
   endtask

   initial begin
      logic seen;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_req", 64'(dmem_req), 64'd0);
      chk("rst_wbdata", WBData, 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // R-type
      run_op(64'h2A, 64'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 64'h0, 1'b0);
      // sd, ready after 3 waiting cycles (lands on the expiring cycle)
      run_op(64'h100, 64'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0, 64'h0, 1'b0);
      // store with immediate ready
      run_op(64'h108, 64'h77, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 64'h0, 1'b0);
      // ld, immediate ready, rvalid two cycles after ready
      run_op(64'h80, 64'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 64'h1234, 1'b0);
      // ld, ready never comes
      run_op(64'h88, 64'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 100, 0, 64'h0, 1'b0);
      // ld, ready in time, rvalid never comes
      run_op(64'h90, 64'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1, 100, 64'h0, 1'b0);
      // illegal MemRead & MemWrite
      run_op(64'h40, 64'h1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 64'h0, 1'b0);
      // sd to unaligned address
      run_op(64'h103, 64'hCAFE, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 64'h0, 1'b0);
      // write to x0 never enables the register file
      run_op(64'h99, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 64'h0, 1'b1);

      // reset while in WAIT_R, then a late rvalid
      @(negedge clk);
      ALUResult = 64'h80; MemRead = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1;
      RegWrite = 1'b1; RdIn = 5'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rst_mid_req", 64'(dmem_req), 64'd1);
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
      chk("rst_mid_wait_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_req_low", 64'(dmem_req), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk("rst_mid_wb", {WBData[62:0], WBRegWrite}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      dmem_rvalid = 1'b1; dmem_rdata = 64'h1234;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         dmem_rvalid = 1'b0;
         if (done || busy || dmem_req) seen = 1'b1;
      end
      chk("rst_late_rvalid", 64'(seen), 64'd0);

      // randomized instruction mix
      for (int n = 0; n < 60; n++) begin
         int kind;
         logic [63:0] a;
         logic mr, mw;
         kind = int'($urandom_range(0, 9));
         a = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
         mr = (kind < 4) || (kind == 9);
         mw = (kind >= 4 && kind < 7) || (kind == 9);
         run_op(a, {$urandom, $urandom}, 5'($urandom_range(0, 31)), mr, mw,
                mr && !mw, 1'($urandom), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 4)), {$urandom, $urandom}, 1'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller of the sequential RISC-V processor, placed between the execute stage and the data memory. It consumes the execute stage's result bundle (ALU result, store data, destination register, MemRead/MemWrite/MemtoReg/RegWrite) and performs the ld/sd access over a valid/ready request channel with a separate read-response channel. It then presents a one-cycle writeback bundle to the register file, holding `busy` high so the processor stalls while an access is outstanding.

## Interface
- `TIMEOUT`, default 255: cycles allowed in REQ plus WAIT_R before the access is aborted; 8-bit counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse, execute bundle valid; ignored while `busy`.
- `ALUResult`  in  64  address for ld/sd, otherwise the writeback value.
- `WriteData`  in  64  store data (rs2).
- `RdIn`  in  5  destination register.
- `MemRead`, `MemWrite`, `MemtoReg`, `RegWrite`  in  1 each  control signals from the execute stage.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse; writeback bundle valid.
- `WBData`  out  64  writeback value.
- `WBRd`  out  5  writeback register.
- `WBRegWrite`  out  1  register-file write enable; qualified by `done`.
- `fault`  out  1  pulses with `done` when the access was aborted.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  64  request address.
- `dmem_wdata`  out  64  store data.
- `dmem_ready`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  64  load data.

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE. All outputs are registered.
- Reset value of every output is 0; the FSM resets to IDLE and the timeout counter to 0.
- On `start` in IDLE, latch the whole bundle, then branch:
  - MemRead and MemWrite both set: illegal. Go to DONE with the fault flag set; no request is issued.
  - Exactly one of MemRead/MemWrite set: go to REQ.
  - Neither set: go to DONE.
- REQ:
  - `dmem_req` = 1, with addr, we and wdata held stable until `dmem_ready`.
  - On `dmem_ready`: a store goes to DONE; a load goes to WAIT_R.
- WAIT_R: on `dmem_rvalid`, capture `dmem_rdata` and go to DONE. `dmem_rvalid` in any other state is ignored.
- Timeout counter:
  - Cleared on entry to REQ.
  - Increments each cycle spent in REQ or WAIT_R.
  - On reaching `TIMEOUT` without completion: drop `dmem_req`, go to DONE with the fault flag set.
  - If completion and timeout occur in the same cycle, completion wins.
- DONE:
  - `done` = 1 for one cycle.
  - `WBData` = MemtoReg ? captured rdata : latched ALUResult.
  - `WBRd` = latched Rd.
  - `WBRegWrite` = RegWrite & !fault & (Rd != 0).
  - Next state is IDLE.
- `start` arriving in any state other than IDLE is dropped. The upstream stage must respect `busy`.
- `rst_n` asserted mid-access returns to IDLE at once and drops `dmem_req`. A late `dmem_ready`/`dmem_rvalid` after reset is ignored.

## Timing
- `start` is sampled at edge T.
- Non-memory instruction: `done` high in cycle T+1.
- Store with `dmem_ready` in its first REQ cycle: `dmem_req` high in T+1, `done` high in T+2.
- Load with immediate ready and `dmem_rvalid` one cycle later: `done` high in T+3.
- `dmem_rvalid` is never expected in the same cycle as the `dmem_ready` for that load.
- `busy` rises in cycle T+1 and falls together with `done` falling.
- Earliest next accepted `start` is the cycle after `done`.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, an ld/sd whose `ALUResult[2:0]` != 0 goes directly to DONE with fault = 1 and no request.
  - `WBRegWrite` is 0 for that instruction.
- Macro undefined: no alignment check; the address is passed to `dmem_addr` unmodified.

## Structure
- Shared package `mem_stage_pkg` holds:
  - the state enum (IDLE/REQ/WAIT_R/DONE),
  - the default `TIMEOUT` constant,
  - the XLEN = 64 constant.
- One sub-module, `dmem_timeout_ctr`, with inputs clear, enable and limit, and output expired.

## Test plan
- R-type, ALUResult = 0x2A, RegWrite = 1, Rd = 5, start at T -> `done` at T+1, WBData = 0x2A, WBRd = 5, WBRegWrite = 1, `dmem_req` never high.
- sd, addr = 0x100, WriteData = 0xDEADBEEF, `dmem_ready` delayed 3 cycles -> `dmem_req` with addr and wdata stable for 4 cycles, `done` next cycle, WBRegWrite = 0.
- ld, addr = 0x80, ready immediate, `dmem_rvalid` 2 cycles later with 0x1234, Rd = 7, MemtoReg = 1 -> WBData = 0x1234, WBRegWrite = 1, `done` at T+4.
- ld with `dmem_ready` never asserted, TIMEOUT = 4 -> `dmem_req` drops after 4 cycles in REQ, `done` = `fault` = 1, WBRegWrite = 0.
- MemRead = MemWrite = 1 -> `done` at T+1 with fault = 1 and no request; with `MEM_ALIGN_CHECK_EN`, sd to 0x103 -> fault = 1 and no request.
- `rst_n` low while in WAIT_R, then `dmem_rvalid` pulse after release -> all outputs 0, state IDLE, `done` never pulses.
